// File: rtl/ahb_pkg.sv
// +------------------------------------------------------------------+
// | ahb_pkg : shared AHB encodings, arbiter states, burst length     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_BURST = 2'd2,
    ARB_LOCK  = 2'd3
  } arb_state_e;

  // Beat count of a fixed-length burst; 0 for SINGLE and undefined-length INCR.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    len = 5'd0;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
      default:                      len = 5'd0;
    endcase
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_rr_pick.sv
// +------------------------------------------------------------------+
// | ahb_rr_pick : first requester at or after ptr, one-hot result    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ahb_rr_pick #(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic                           valid
);

  localparam int IW = $clog2(NUM_MASTERS);

  logic [IW:0] w_sum;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_sum = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      // One extra bit keeps ptr+i from overflowing before the modulo wrap.
      w_sum = {1'b0, ptr} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(NUM_MASTERS)) begin
        w_sum = w_sum - (IW+1)'(NUM_MASTERS);
      end
      if (!valid && req[w_sum[IW-1:0]]) begin
        grant[w_sum[IW-1:0]] = 1'b1;
        valid                = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahb_arbiter.sv
// +------------------------------------------------------------------+
// | ahb_arbiter : round-robin AHB arbiter with burst/lock hold & mux |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                                hclk,
  input  logic                                hresetn,
  input  logic [NUM_MASTERS-1:0]              hbusreq_m,
  input  logic [NUM_MASTERS-1:0]              hlock_m,
  input  logic [NUM_MASTERS-1:0][31:0]        haddr_m,
  input  logic [NUM_MASTERS-1:0][31:0]        hwdata_m,
  input  logic [NUM_MASTERS-1:0][1:0]         htrans_m,
  input  logic [NUM_MASTERS-1:0][2:0]         hsize_m,
  input  logic [NUM_MASTERS-1:0][2:0]         hburst_m,
  input  logic [NUM_MASTERS-1:0]              hwrite_m,
  input  logic                                hready,
  output logic [NUM_MASTERS-1:0]              hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0]      hmaster,
  output logic [$clog2(NUM_MASTERS)-1:0]      hmaster_d,
  output logic [31:0]                         haddr,
  output logic [1:0]                          htrans,
  output logic [2:0]                          hsize,
  output logic [2:0]                          hburst,
  output logic                                hwrite,
  output logic [31:0]                         hwdata,
  output logic                                hmastlock
);

  localparam int                     IW            = $clog2(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [IW-1:0]          DEFAULT_IDX   = IW'(DEFAULT_MASTER);

  arb_state_e               state_q, state_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [3:0]               beat_q, beat_d;
  logic [IW-1:0]            amaster_q, amaster_d;
  logic [IW-1:0]            dmaster_q, dmaster_d;
  logic                     mastlock_q, mastlock_d;

  logic [NUM_MASTERS-1:0]   pick_grant;
  logic                     pick_valid;
  logic [IW-1:0]            pick_idx;
  logic [IW-1:0]            grant_idx;
  logic [1:0]               cur_trans;
  logic [4:0]               cur_len;
  logic                     arbitrate;

  ahb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_pick (
    .req   (hbusreq_m),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx  = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_grant[i]) pick_idx  = IW'(i);
      if (grant_q[i])    grant_idx = IW'(i);
    end
  end

  // Burst tracking follows the address-phase owner, not the pending grant.
  assign cur_trans = htrans_m[amaster_q];
  assign cur_len   = burst_len(hburst_m[amaster_q]);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    beat_d     = beat_q;
    amaster_d  = amaster_q;
    dmaster_d  = dmaster_q;
    mastlock_d = mastlock_q;
    arbitrate  = 1'b0;
    if (hready) begin
      amaster_d  = grant_idx;
      dmaster_d  = amaster_q;
      mastlock_d = hlock_m[amaster_q];
      case (state_q)
        ARB_IDLE, ARB_OWN: begin
          if (hlock_m[grant_idx]) begin
            state_d = ARB_LOCK;
          end else if (state_q == ARB_OWN && cur_trans == HTRANS_NONSEQ && cur_len != 5'd0) begin
            state_d = ARB_BURST;
            beat_d  = 4'(cur_len - 5'd1);
          end else begin
            arbitrate = 1'b1;
          end
        end
        ARB_BURST: begin
          if (cur_trans == HTRANS_SEQ) begin
            if (beat_q <= 4'd1) begin
              beat_d    = 4'd0;
              arbitrate = 1'b1;
            end else begin
              beat_d = beat_q - 4'd1;
            end
          end else if (cur_trans == HTRANS_NONSEQ && cur_len != 5'd0) begin
            beat_d = 4'(cur_len - 5'd1);
          end else if (cur_trans != HTRANS_BUSY) begin
            beat_d  = 4'd0;
            state_d = ARB_OWN;
          end
        end
        ARB_LOCK: begin
          if (!hlock_m[grant_idx]) state_d = ARB_OWN;
        end
        default: state_d = ARB_IDLE;
      endcase
      if (arbitrate) begin
        if (pick_valid) begin
          grant_d = pick_grant;
          ptr_d   = (pick_idx == IW'(NUM_MASTERS-1)) ? '0 : pick_idx + IW'(1);
          state_d = ARB_OWN;
        end else begin
          grant_d = DEFAULT_GRANT;
          state_d = ARB_IDLE;
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ARB_IDLE;
      grant_q    <= DEFAULT_GRANT;
      ptr_q      <= DEFAULT_IDX;
      beat_q     <= 4'd0;
      amaster_q  <= DEFAULT_IDX;
      dmaster_q  <= DEFAULT_IDX;
      mastlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      beat_q     <= beat_d;
      amaster_q  <= amaster_d;
      dmaster_q  <= dmaster_d;
      mastlock_q <= mastlock_d;
    end
  end

  assign hgrant    = grant_q;
  assign hmaster   = amaster_q;
  assign hmaster_d = dmaster_q;
  assign hmastlock = mastlock_q;
  assign haddr     = haddr_m[amaster_q];
  assign htrans    = htrans_m[amaster_q];
  assign hsize     = hsize_m[amaster_q];
  assign hburst    = hburst_m[amaster_q];
  assign hwrite    = hwrite_m[amaster_q];
  assign hwdata    = hwdata_m[dmaster_q];

endmodule

`default_nettype wire
